// File: rtl/dma_rd_rsp_if.sv
// Bus bundle for dma_rd_rsp: request handshake, memory read port,
// response handshake and status. addr_err exists only with ADDR_CHK_EN.
interface dma_rd_rsp_if #(
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       addr;
    logic              req_pad;
    logic              mem_en;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;
    logic              busy;
`ifdef ADDR_CHK_EN
    logic              addr_err;
`endif

    // Responder side.
    modport slave (
        input  req_valid, addr, req_pad, mem_rdata, rsp_ready,
        output req_ready, mem_en, mem_addr, rsp_valid, rsp_data, busy
`ifdef ADDR_CHK_EN
        , addr_err
`endif
    );

    // Requester / memory / consumer side.
    modport master (
        output req_valid, addr, req_pad, mem_rdata, rsp_ready,
        input  req_ready, mem_en, mem_addr, rsp_valid, rsp_data, busy
`ifdef ADDR_CHK_EN
        , addr_err
`endif
    );
endinterface

// File: rtl/dma_rd_rsp.sv
// dma_rd_rsp: DMA read responder. Accepts word addresses, reads a
// fixed-latency memory, returns data (zero for padding requests) in request
// order through a first-word-fall-through FIFO. A credit counter bounds
// outstanding requests to the FIFO depth, so a push never meets a full FIFO.
// Optional macro ADDR_CHK_EN: out-of-range addresses (>= MEM_WORDS) are
// answered as padding and raise the sticky addr_err flag.
module dma_rd_rsp #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 8
`ifdef ADDR_CHK_EN
    , parameter int unsigned MEM_WORDS = 65536
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dma_rd_rsp_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic              accept_w;
    logic              pop_w;
    logic              push_w;
    logic              wr_en_w;
    logic              full_w;
    logic              empty_w;
    logic              oor_w;
    logic              pad_eff_w;
    logic [DATA_W-1:0] push_data_w;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q;
    logic              mem_en_q;
    logic [31:0]       mem_addr_q;
    logic [MEM_LAT:0]  tag_vld_q;
    logic [MEM_LAT:0]  tag_pad_q;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    // Extra MSB on the pointers distinguishes full from empty.
    logic [CNT_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  rd_ptr_q;

    assign accept_w = bus.req_valid & req_ready_q;
    assign pop_w    = ~empty_w & bus.rsp_ready;

`ifdef ADDR_CHK_EN
    assign oor_w = (bus.addr >= 32'(MEM_WORDS));
`else
    assign oor_w = 1'b0;
`endif
    assign pad_eff_w = bus.req_pad | oor_w;

    // Credit count: accepted minus popped.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_w && !pop_w) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept_w && pop_w) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Credit register and registered ready derived from next credit count.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            req_ready_q <= (cnt_d < CNT_W'(FIFO_DEPTH));
        end
    end

    // Memory read issue; address holds while idle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_en_q <= accept_w & ~pad_eff_w;
            if (accept_w && !pad_eff_w) begin
                mem_addr_q <= bus.addr;
            end
        end
    end

    // Tag pipeline aligned with memory latency; pads ride along to keep order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tag_vld_q <= '0;
            tag_pad_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[MEM_LAT-1:0], accept_w};
            tag_pad_q <= {tag_pad_q[MEM_LAT-1:0], pad_eff_w};
        end
    end

    assign push_w      = tag_vld_q[MEM_LAT];
    assign push_data_w = tag_pad_q[MEM_LAT] ? '0 : bus.mem_rdata;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign wr_en_w = push_w & ~full_w;

    // FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_w) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i) begin
        if (wr_en_w) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_data_w;
        end
    end

`ifdef ADDR_CHK_EN
    logic addr_err_q;

    // Sticky out-of-range flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            addr_err_q <= 1'b0;
        end else if (accept_w && !bus.req_pad && oor_w) begin
            addr_err_q <= 1'b1;
        end
    end

    assign bus.addr_err = addr_err_q;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_valid = ~empty_w;
    assign bus.rsp_data  = empty_w ? '0 : fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_dma_rd_rsp.sv
// Testbench for dma_rd_rsp: fixed-latency memory model plus a queue-based
// reference of outstanding requests (data and cycle of first visibility).
module tb_dma_rd_rsp;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned DEPTH   = 8;
`ifdef ADDR_CHK_EN
    localparam int unsigned MEM_WORDS = 729;
    localparam logic [31:0] RD_ADDR   = 32'd512;
`else
    localparam logic [31:0] RD_ADDR   = 32'd1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dma_rd_rsp_if #(.DATA_W(DATA_W)) bus ();

    dma_rd_rsp #(
        .DATA_W(DATA_W),
        .MEM_LAT(MEM_LAT),
        .FIFO_DEPTH(DEPTH)
`ifdef ADDR_CHK_EN
        , .MEM_WORDS(MEM_WORDS)
`endif
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                avail;
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   mem_en_cnt = 0;

    function automatic logic [DATA_W-1:0] mem_fn(input logic [31:0] a);
        logic [31:0] h;
        if (a == RD_ADDR) return 16'h00AB;
        if (a == 32'd5)   return 16'h1111;
        if (a == 32'd6)   return 16'h2222;
        h = a * 32'h9E37_79B1;
        return h[31:16] ^ a[15:0];
    endfunction

    function automatic logic [DATA_W-1:0] exp_of(input logic [31:0] a, input logic pad);
        if (pad) return '0;
`ifdef ADDR_CHK_EN
        if (a >= MEM_WORDS) return '0;
`endif
        return mem_fn(a);
    endfunction

    // Memory: data for a strobe in cycle c appears in cycle c+MEM_LAT; junk otherwise.
    logic [DATA_W-1:0] mpipe [MEM_LAT];
    always @(posedge clk) begin
        mpipe[0] <= (bus.mem_en === 1'b1) ? mem_fn(bus.mem_addr) : DATA_W'($urandom);
        for (int k = 1; k < MEM_LAT; k++) mpipe[k] <= mpipe[k-1];
        if (bus.mem_en === 1'b1) mem_en_cnt <= mem_en_cnt + 1;
    end
    assign bus.mem_rdata = mpipe[MEM_LAT-1];

    // A push into a full FIFO must never happen.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(dut.push_w && dut.full_w))
            else begin
                failures++;
                $display("FAIL fifo_overflow push into full FIFO at cyc=%0d", cyc);
            end
        end
    end

    // One clock: record handshakes in the reference, then advance.
    task automatic tick(output bit acc, output bit pop);
        exp_t e;
        acc = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1);
        pop = (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b1);
        if (pop && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            e.data  = exp_of(bus.addr, bus.req_pad);
            e.avail = cyc + int'(MEM_LAT) + 2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        bit a, p;
        bus.req_valid = 1'b0; bus.req_pad = 1'b0; bus.addr = '0; bus.rsp_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.mem_en, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b en=%b maddr=%0h vld=%b data=%0h busy=%b want all 0",
                     bus.req_ready, bus.mem_en, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.busy);
        end
        rst = 1'b1;
        tick(a, p);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got %b want 1", bus.req_ready);
        end
        // Three requests in flight, then reset.
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addr = 32'(10 + i);
            tick(a, p);
        end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        tick(a, p);
        checks++;
        if ({bus.req_ready, bus.mem_en, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.busy} !== '0) begin
            failures++;
            $display("FAIL reset_midflight got rdy=%b en=%b maddr=%0h vld=%b data=%0h busy=%b want all 0",
                     bus.req_ready, bus.mem_en, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.busy);
        end
`ifdef ADDR_CHK_EN
        checks++;
        if (bus.addr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_addr_err got %b want 0", bus.addr_err);
        end
`endif
        tick(a, p);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_discard cyc=%0d got vld=%b busy=%b want 0 0", cyc, bus.rsp_valid, bus.busy);
            end
            tick(a, p);
        end
    endtask

    task automatic test_single_read();
        bit a, p;
        int n0;
        n0 = mem_en_cnt;
        bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_pad = 1'b0; bus.addr = RD_ADDR;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got %b want 1", bus.req_ready);
        end
        tick(a, p);
        bus.req_valid = 1'b0; bus.addr = $urandom;
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== RD_ADDR) begin
            failures++;
            $display("FAIL single_issue got en=%b addr=%0d want 1 %0d", bus.mem_en, bus.mem_addr, RD_ADDR);
        end
        for (int k = 1; k <= int'(MEM_LAT) + 1; k++) begin
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_early t+%0d got vld=%b want 0", k, bus.rsp_valid);
            end
            if (k == 2) begin
                checks++;
                if (bus.mem_en !== 1'b0 || bus.mem_addr !== RD_ADDR) begin
                    failures++;
                    $display("FAIL single_hold got en=%b addr=%0d want 0 %0d", bus.mem_en, bus.mem_addr, RD_ADDR);
                end
            end
            tick(a, p);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h00AB || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_rsp got vld=%b data=%h busy=%b want 1 00ab 1", bus.rsp_valid, bus.rsp_data, bus.busy);
        end
        tick(a, p);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || mem_en_cnt - n0 != 1) begin
            failures++;
            $display("FAIL single_done got vld=%b busy=%b strobes=%0d want 0 0 1", bus.rsp_valid, bus.busy, mem_en_cnt - n0);
        end
    endtask

    task automatic test_mixed_pad();
        bit a, p;
        int n0;
        logic [DATA_W-1:0] got[$];
        logic [DATA_W-1:0] want [3];
        want[0] = 16'h1111; want[1] = 16'h0000; want[2] = 16'h2222;
        n0 = mem_en_cnt;
        bus.rsp_ready = 1'b1; bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_pad = (i == 1);
            bus.addr    = (i == 0) ? 32'd5 : (i == 2) ? 32'd6 : 32'(5 + $urandom_range(0, 1));
            if (bus.rsp_valid === 1'b1) got.push_back(bus.rsp_data);
            tick(a, p);
        end
        bus.req_valid = 1'b0; bus.req_pad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid === 1'b1) got.push_back(bus.rsp_data);
            tick(a, p);
        end
        checks++;
        if (got.size() != 3 || mem_en_cnt - n0 != 2) begin
            failures++;
            $display("FAIL mixed_count got rsps=%0d strobes=%0d want 3 2", got.size(), mem_en_cnt - n0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== want[i]) begin
                failures++;
                $display("FAIL mixed_data idx=%0d got %h (of %0d) want %h", i, (i < got.size()) ? got[i] : 16'hxxxx, got.size(), want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit a, p;
        int nacc;
        nacc = 0;
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_pad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.addr = 32'(300 + nacc);
            tick(a, p);
            if (a) nacc++;
        end
        checks++;
        if (nacc != int'(DEPTH) || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL full_stop got accepts=%0d rdy=%b vld=%b busy=%b want %0d 0 1 1",
                     nacc, bus.req_ready, bus.rsp_valid, bus.busy, DEPTH);
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) bus.req_valid = 1'b0;
            bus.addr = 32'(300 + nacc);
            checks++;
            if (bus.req_ready !== (q.size() < DEPTH)) begin
                failures++;
                $display("FAIL bp_ready cyc=%0d got %b want %b", cyc, bus.req_ready, q.size() < DEPTH);
            end
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if (q.size() == 0 || bus.rsp_data !== q[0].data) begin
                    failures++;
                    $display("FAIL bp_data cyc=%0d got %h want %h", cyc, bus.rsp_data, (q.size() > 0) ? q[0].data : 16'hxxxx);
                end
            end
            tick(a, p);
            if (a) nacc++;
        end
        checks++;
        if (q.size() != 0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got pending=%0d busy=%b vld=%b want 0 0 0", q.size(), bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_stream_wrap();
        bit a, p, ev;
        int nacc, npop, first, last, t0;
        nacc = 0; npop = 0; first = -1; last = -1;
        bus.rsp_ready = 1'b1; bus.req_pad = 1'b0; bus.req_valid = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 160; i++) begin
            if (nacc == 100) bus.req_valid = 1'b0;
            bus.addr = 32'(nacc);
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            checks++;
            if (bus.req_ready !== (q.size() < DEPTH) || bus.busy !== (q.size() != 0) || bus.rsp_valid !== ev) begin
                failures++;
                $display("FAIL stream_ctl cyc=%0d got rdy/busy/vld=%b%b%b want %b%b%b", cyc,
                         bus.req_ready, bus.busy, bus.rsp_valid, q.size() < DEPTH, q.size() != 0, ev);
            end
            if (ev) begin
                checks++;
                if (bus.rsp_data !== q[0].data) begin
                    failures++;
                    $display("FAIL stream_data cyc=%0d got %h want %h", cyc, bus.rsp_data, q[0].data);
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            tick(a, p);
            if (a) nacc++;
            if (p) npop++;
            if (nacc == 100 && a) begin
                checks++;
                if (cyc - t0 != 100) begin
                    failures++;
                    $display("FAIL stream_accept_rate got %0d cycles want 100", cyc - t0);
                end
            end
        end
        checks++;
        if (nacc != 100 || npop != 100 || last - first != 99) begin
            failures++;
            $display("FAIL stream_total got acc=%0d rsp=%0d span=%0d want 100 100 99", nacc, npop, last - first);
        end
    endtask

`ifdef ADDR_CHK_EN
    task automatic test_addr_chk();
        bit a, p;
        int n0;
        bit seen;
        checks++;
        if (bus.addr_err !== 1'b0) begin
            failures++;
            $display("FAIL chk_initial got addr_err=%b want 0", bus.addr_err);
        end
        for (int r = 0; r < 2; r++) begin
            n0 = mem_en_cnt;
            bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_pad = 1'b0;
            bus.addr = (r == 0) ? 32'd2399 : 32'd728;
            tick(a, p);
            bus.req_valid = 1'b0;
            checks++;
            if (bus.mem_en !== (r == 1) || bus.addr_err !== 1'b1) begin
                failures++;
                $display("FAIL chk_issue addr=%0d got en=%b err=%b want %b 1", (r == 0) ? 2399 : 728, bus.mem_en, bus.addr_err, r == 1);
            end
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (bus.rsp_valid === 1'b1 && !seen) begin
                    seen = 1'b1;
                    checks++;
                    if (bus.rsp_data !== ((r == 0) ? 16'h0000 : mem_fn(32'd728))) begin
                        failures++;
                        $display("FAIL chk_data r=%0d got %h want %h", r, bus.rsp_data, (r == 0) ? 16'h0000 : mem_fn(32'd728));
                    end
                end
                tick(a, p);
            end
            checks++;
            if (!seen || bus.addr_err !== 1'b1 || mem_en_cnt - n0 != r) begin
                failures++;
                $display("FAIL chk_done r=%0d got seen=%b err=%b strobes=%0d want 1 1 %0d", r, seen, bus.addr_err, mem_en_cnt - n0, r);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit a, p, ev;
        for (int i = 0; i < 500; i++) begin
            if (i < 450) begin
                bus.req_valid = ($urandom_range(0, 9) < 7);
                bus.req_pad   = ($urandom_range(0, 3) == 0);
                bus.addr      = $urandom_range(0, 1500);
                bus.rsp_ready = ($urandom_range(0, 9) < 6);
            end else begin
                bus.req_valid = 1'b0;
                bus.rsp_ready = 1'b1;
            end
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            checks++;
            if (bus.req_ready !== (q.size() < DEPTH) || bus.busy !== (q.size() != 0) || bus.rsp_valid !== ev) begin
                failures++;
                $display("FAIL random_ctl cyc=%0d got rdy/busy/vld=%b%b%b want %b%b%b", cyc,
                         bus.req_ready, bus.busy, bus.rsp_valid, q.size() < DEPTH, q.size() != 0, ev);
            end
            if (ev) begin
                checks++;
                if (bus.rsp_data !== q[0].data) begin
                    failures++;
                    $display("FAIL random_data cyc=%0d got %h want %h", cyc, bus.rsp_data, q[0].data);
                end
            end
            tick(a, p);
        end
        checks++;
        if (q.size() != 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL random_drain got pending=%0d busy=%b want 0 0", q.size(), bus.busy);
        end
`ifdef ADDR_CHK_EN
        checks++;
        if (bus.addr_err !== 1'b1) begin
            failures++;
            $display("FAIL random_addr_err got %b want 1", bus.addr_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_mixed_pad();
        test_backpressure();
        test_stream_wrap();
`ifdef ADDR_CHK_EN
        test_addr_chk();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
